// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add unsigned multiplier that stalls the execute stage until the product is ready.
// Optional build macro MULT_SEQ_EARLY_TERM_EN: a zero operand skips RUN and completes in one cycle.

module mult_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] srca,
  input  logic [DATA_W-1:0] srcb,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic [DATA_W-1:0] product_hi,
  output logic [1:0]        dbg_state_o
);

  // Handshake: start is a level request; it is accepted on the IDLE cycle where
  // start=1 and abort=0, and done pulses for exactly one cycle when the product is valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W:0]   sum;
  logic              accept;
  logic              zero_op;

  assign accept = (state_q == S_IDLE) && start && !abort;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign zero_op = (srca == '0) || (srcb == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Carry out of the add lands in sum[DATA_W] and is shifted into the hi MSB.
  assign sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = zero_op ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort)                   state_d = S_IDLE;
        else if (cnt_q == LAST_STEP) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      cnt_d = '0;
      a_d   = srca;
      hi_d  = '0;
      lo_d  = zero_op ? '0 : srcb;
    end else if ((state_q == S_RUN) && !abort) begin
      cnt_d = cnt_q + CNT_W'(1);
      hi_d  = sum[DATA_W:1];
      lo_d  = {sum[0], lo_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    stall       = accept || (state_q == S_RUN);
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    product     = lo_q;
    product_hi  = hi_q;
    dbg_state_o = state_q;
  end

endmodule
